alu_arbiter: RTL and testbench

Shares the single 16-bit combinational ALU between two requesters (e.g. the fetch/branch unit and the execute stage). Accepts one operation at a time with a valid/ready handshake and selects fairly with a round-robin pointer. Drives the ALU from registered operand latches and returns a registered result on a shared response channel tagged with the requester ID. The ALU instance sits outside this block; its inputs are driven only by this block.

---
 rtl/alu_ctrl_pkg.sv | 33 +++
 rtl/rr_arb2.sv | 21 ++
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: widths, opcodes, arbiter state and request payload.
package alu_ctrl_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OP_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(1);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SHR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MAX = OP_W'(5);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // One operation as presented by a requester
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } alu_req_t;

  // Opcodes above OP_MAX have no ALU meaning
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_MAX;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; the pointer only matters when both inputs are valid.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // Contested requests go to the pointer, otherwise the lone valid wins
  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    if (valid == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else begin
      gnt = valid;
    end
    gnt_idx = gnt[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters with round-robin
// arbitration, registered ALU operands and a registered, ID-tagged response.
module alu_arbiter
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [WIDTH-1:0]  alu_r,
  input  logic              alu_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_r,
  output logic              rsp_cout,
  output logic              rsp_zero,
  output logic              rsp_error
);

  state_t     state_q;
  state_t     state_d;
  logic       ptr_q;
  logic [1:0] gnt;
  logic       gnt_idx;
  logic       accept;
  logic       capture;
  logic       rsp_done;
  alu_req_t   req_sel;
  logic       op_bad;

  rr_arb2 u_arb (
    .valid   ({req1_valid, req0_valid}),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Payload of whichever requester holds the grant
  always_comb begin
    req_sel = gnt_idx ? alu_req_t'{op: req1_op, a: req1_a, b: req1_b}
                      : alu_req_t'{op: req0_op, a: req0_a, b: req0_b};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Readies are only ever raised in IDLE, towards the granted requester
  assign req0_ready = accept & gnt[0];
  assign req1_ready = accept & gnt[1];

  assign op_bad = op_illegal(alu_op);

  // Operand latches, response capture and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_r     <= '0;
      rsp_cout  <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_error <= 1'b0;
      ptr_q     <= 1'b0;
    end else begin
      if (accept) begin
        alu_a  <= req_sel.a;
        alu_b  <= req_sel.b;
        alu_op <= req_sel.op;
        rsp_id <= gnt_idx;
      end
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_r     <= op_bad ? '0 : alu_r;
        rsp_cout  <= (alu_op == OP_ADD) & alu_cout;
        rsp_zero  <= op_bad | (alu_r == '0);
        rsp_error <= op_bad;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
        ptr_q     <= ~rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter with a transaction-level reference model.
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]        req0_op, req1_op, alu_op;
  logic [15:0]       req0_a, req0_b, req1_a, req1_b;
  logic [15:0]       alu_a, alu_b, alu_r, rsp_r;
  logic              alu_cout, rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero, rsp_error;

  int vectors = 0;
  int miscompares = 0;

  // Drive shadows, applied to the DUT just after each falling edge
  bit          d_rst, d_v0, d_v1, d_rr;
  logic [3:0]  d_op0, d_op1;
  logic [15:0] d_a0, d_b0, d_a1, d_b1;

  // Reference model state
  int          m_stage;  // 0 free, 1 operation in flight, 2 response pending
  bit          m_ptr, m_rsp_valid, m_rsp_id, m_cout, m_zero, m_err;
  int unsigned m_r, m_a, m_b, m_op;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; raises carry on non-add ops and returns junk on illegal ops
  always_comb begin
    logic [31:0] t;
    t        = '0;
    alu_r    = '0;
    alu_cout = 1'b0;
    case (alu_op)
      4'd0: begin t = 32'(alu_a) + 32'(alu_b); alu_r = t[15:0]; alu_cout = t[16]; end
      4'd1: begin alu_r = alu_a & alu_b; alu_cout = 1'b1; end
      4'd2: begin alu_r = alu_a | alu_b; alu_cout = 1'b1; end
      4'd3: begin t = 32'(alu_a) << alu_b; alu_r = t[15:0]; alu_cout = |t[31:16]; end
      4'd4: begin alu_r = alu_a >> alu_b; alu_cout = 1'b1; end
      4'd5: begin alu_r = alu_a - alu_b; alu_cout = (alu_a < alu_b); end
      default: begin alu_r = alu_a ^ alu_b ^ 16'hA5A5; alu_cout = 1'b1; end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected architectural result of one operation
  task automatic ref_op(input int unsigned op, input int unsigned a, input int unsigned b,
                        output int unsigned r, output bit c, output bit err);
    r = 0; c = 0; err = 0;
    case (op)
      0: begin r = (a + b) % 65536; c = (a + b) > 65535; end
      1: r = a & b;
      2: r = a | b;
      3: r = (b >= 16) ? 0 : (a << b) % 65536;
      4: r = (b >= 16) ? 0 : a >> b;
      5: r = (a + 65536 - b) % 65536;
      default: err = 1;
    endcase
  endtask

  task automatic model_reset();
    m_stage = 0; m_ptr = 0; m_rsp_valid = 0; m_rsp_id = 0;
    m_cout = 0; m_zero = 0; m_err = 0; m_r = 0; m_a = 0; m_b = 0; m_op = 0;
  endtask

  // One clock cycle: apply inputs, compare DUT with the model, advance the model
  task automatic step();
    int g;
    int unsigned r;
    bit c, e;
    @(negedge clk);
    rst_n = d_rst; rsp_ready = d_rr;
    req0_valid = d_v0; req0_op = d_op0; req0_a = d_a0; req0_b = d_b0;
    req1_valid = d_v1; req1_op = d_op1; req1_a = d_a1; req1_b = d_b1;
    #1;
    if (!d_rst) model_reset();
    g = -1;
    if (m_stage == 0) begin
      if (d_v0 && d_v1) g = int'(m_ptr);
      else if (d_v0)    g = 0;
      else if (d_v1)    g = 1;
    end
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_op", alu_op, m_op);
    check("rsp_valid", rsp_valid, m_rsp_valid);
    check("rsp_id", rsp_id, m_rsp_id);
    check("rsp_r", rsp_r, m_r);
    check("rsp_cout", rsp_cout, m_cout);
    check("rsp_zero", rsp_zero, m_zero);
    check("rsp_error", rsp_error, m_err);
    if (d_rst) begin
      case (m_stage)
        0: if (g >= 0) begin
             m_op = (g == 1) ? d_op1 : d_op0;
             m_a  = (g == 1) ? d_a1  : d_a0;
             m_b  = (g == 1) ? d_b1  : d_b0;
             m_rsp_id = (g == 1);
             m_stage = 1;
           end
        1: begin
             ref_op(m_op, m_a, m_b, r, c, e);
             m_r = e ? 0 : r; m_cout = c; m_zero = (m_r == 0); m_err = e;
             m_rsp_valid = 1; m_stage = 2;
           end
        default: if (d_rr) begin
             m_rsp_valid = 0; m_stage = 0; m_ptr = !m_rsp_id;
           end
      endcase
    end
  endtask

  // Step until a response is visible, bounded
  task automatic wait_rsp();
    int n = 0;
    do begin step(); n++; end while (!rsp_valid && n < 12);
    check("rsp_timeout", rsp_valid, 1'b1);
  endtask

  task automatic do_reset();
    d_v0 = 0; d_v1 = 0; d_rst = 0;
    step(); step();
    d_rst = 1;
  endtask

  task automatic set0(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    d_v0 = 1; d_op0 = op; d_a0 = a; d_b0 = b;
  endtask

  task automatic set1(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    d_v1 = 1; d_op1 = op; d_a1 = a; d_b1 = b;
  endtask

  function automatic logic [3:0] rnd_op();
    int unsigned r = $urandom_range(0, 19);
    return (r < 14) ? 4'(r % 6) : 4'($urandom_range(6, 15));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ids [4];
    logic [15:0] rs [4];
    model_reset();
    d_rst = 0; d_v0 = 0; d_v1 = 0; d_rr = 1;
    d_op0 = 0; d_op1 = 0; d_a0 = 0; d_b0 = 0; d_a1 = 0; d_b1 = 0;

    // Reset values
    step(); step();
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_alu_op", alu_op, 4'h0);
    check("rst_req0_ready", req0_ready, 1'b0);
    d_rst = 1;

    // Add with carry out and zero result
    set0(4'd0, 16'hFFFF, 16'h0001);
    step();
    check("t1_req0_ready", req0_ready, 1'b1);
    check("t1_req1_ready", req1_ready, 1'b0);
    d_v0 = 0;
    step();
    check("t1_exec_valid", rsp_valid, 1'b0);
    step();
    check("t1_valid", rsp_valid, 1'b1);
    check("t1_id", rsp_id, 1'b0);
    check("t1_r", rsp_r, 16'h0000);
    check("t1_cout", rsp_cout, 1'b1);
    check("t1_zero", rsp_zero, 1'b1);
    check("t1_error", rsp_error, 1'b0);

    // Contested requests alternate starting with req0
    do_reset();
    set0(4'd5, 16'h0005, 16'h0003);
    set1(4'd2, 16'h00F0, 16'h000F);
    for (int k = 0; k < 4; k++) begin
      wait_rsp();
      ids[k] = 4'(rsp_id);
      rs[k]  = rsp_r;
    end
    check("t2_id0", ids[0], 4'd0);
    check("t2_r0", rs[0], 16'h0002);
    check("t2_id1", ids[1], 4'd1);
    check("t2_r1", rs[1], 16'h00FF);
    check("t2_id2", ids[2], 4'd0);
    check("t2_id3", ids[3], 4'd1);

    // Illegal opcode from req1, then a normal op from req0
    d_v0 = 0;
    set1(4'd9, 16'h1234, 16'h5678);
    wait_rsp();
    d_v1 = 0;
    check("t3_error", rsp_error, 1'b1);
    check("t3_r", rsp_r, 16'h0000);
    check("t3_zero", rsp_zero, 1'b1);
    check("t3_cout", rsp_cout, 1'b0);
    check("t3_id", rsp_id, 1'b1);
    set0(4'd1, 16'hFF00, 16'h0F0F);
    step();
    check("t3_next_ready", req0_ready, 1'b1);
    d_v0 = 0;
    wait_rsp();
    check("t3_next_r", rsp_r, 16'h0F00);

    // Backpressure: response held while both requesters wait
    set0(4'd0, 16'h0001, 16'h0002);
    set1(4'd0, 16'h0010, 16'h0020);
    d_rr = 0;
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_hold_ready", {req1_ready, req0_ready}, 2'b00);
      check("t4_hold_valid", rsp_valid, 1'b1);
      check("t4_hold_r", rsp_r, 16'h0030);
    end
    d_rr = 1;
    step();
    step();
    check("t4_regrant", {req1_ready, req0_ready}, 2'b01);
    d_v0 = 0; d_v1 = 0;
    wait_rsp();
    check("t4_r", rsp_r, 16'h0003);
    check("t4_id", rsp_id, 1'b0);

    // Reset during EXEC discards the operation
    set0(4'd0, 16'h0007, 16'h0008);
    step();
    check("t5_ready", req0_ready, 1'b1);
    d_v0 = 0; d_rst = 0;
    step();
    check("t5_rst_valid", rsp_valid, 1'b0);
    check("t5_rst_alu_a", alu_a, 16'h0000);
    check("t5_rst_alu_op", alu_op, 4'h0);
    d_rst = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5_no_rsp", rsp_valid, 1'b0);
    end

    // Shift that carries out of the ALU reports no carry
    set0(4'd3, 16'h8000, 16'h0001);
    step();
    d_v0 = 0;
    wait_rsp();
    check("t6_r", rsp_r, 16'h0000);
    check("t6_cout", rsp_cout, 1'b0);
    check("t6_zero", rsp_zero, 1'b1);
    check("t6_error", rsp_error, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      d_rst = ($urandom_range(0, 499) != 0);
      d_rr  = ($urandom_range(0, 3) != 0);
      d_v0  = ($urandom_range(0, 2) != 0);
      d_v1  = ($urandom_range(0, 2) != 0);
      d_op0 = rnd_op();
      d_op1 = rnd_op();
      d_a0  = 16'($urandom);
      d_a1  = 16'($urandom);
      d_b0  = $urandom_range(0, 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      d_b1  = $urandom_range(0, 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
